// File: rtl/bcd_field_timer_pkg.sv
// Shared constants, state encoding and 2-digit BCD helpers for the field timer.
package bcd_field_timer_pkg;

  localparam int unsigned BCD_BIT_WIDTH = 4;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_ZERO = 4'd0;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_FIVE = 4'd5;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    ST_SET   = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // One base-60 field: [7:4] tens, [3:0] ones.
  typedef logic [2*BCD_BIT_WIDTH-1:0] bcd2_t;

  // 00..59 increment, wrapping 59 -> 00.
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    if (v[3:0] == BCD_NINE) begin
      if (v[7:4] == BCD_FIVE) return '0;
      return {v[7:4] + 4'd1, BCD_ZERO};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // 00..59 decrement, wrapping 00 -> 59.
  function automatic bcd2_t bcd2_dec(input bcd2_t v);
    if (v[3:0] == BCD_ZERO) begin
      if (v[7:4] == BCD_ZERO) return {BCD_FIVE, BCD_NINE};
      return {v[7:4] - 4'd1, BCD_NINE};
    end
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/bcd_field_timer_if.sv
// Pushbutton inputs and display/status outputs of the field timer.
interface bcd_field_timer_if #(
  parameter int unsigned FIELDS = 2
) ();
  logic                  pb_start;
  logic                  pb_clear;
  logic [FIELDS-1:0]     pb_set;
  logic                  mode;
  logic [8*FIELDS-1:0]   digits;
  logic [1:0]            state;
  logic                  running;
  logic                  done;

  modport master (
    output pb_start, pb_clear, pb_set, mode,
    input  digits, state, running, done
  );

  modport slave (
    input  pb_start, pb_clear, pb_set, mode,
    output digits, state, running, done
  );
endinterface

// File: rtl/bcd_field_timer_field.sv
// One base-60 BCD field (00..59) with chained carry/borrow.
module bcd_mod60_field
  import bcd_field_timer_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  inc,       // count tick / carry in
  input  logic  dec,       // count tick / borrow in
  input  logic  set_inc,   // manual increment, never carries
  input  logic  clr,
  input  logic  load,
  input  bcd2_t load_val,
  output bcd2_t q,
  output logic  carry,
  output logic  borrow,
  output logic  is_zero,
  output logic  is_max
);

  bcd2_t value_q, value_d;

  assign q       = value_q;
  assign is_zero = (value_q == '0);
  assign is_max  = (value_q == {BCD_FIVE, BCD_NINE});
  assign carry   = inc && is_max;
  assign borrow  = dec && is_zero;

  // Next field value: clear > load > increment > decrement.
  always_comb begin
    value_d = value_q;
    if (clr)                value_d = '0;
    else if (load)          value_d = load_val;
    else if (inc || set_inc) value_d = bcd2_inc(value_q);
    else if (dec)           value_d = bcd2_dec(value_q);
  end

  // Field register.
  always_ff @(posedge clk) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

endmodule

// File: rtl/bcd_field_timer.sv
// Settable up/down BCD timer over FIELDS base-60 fields with prescaler,
// pause/resume, terminal detection and preset reload.
module bcd_field_timer
  import bcd_field_timer_pkg::*;
#(
  parameter int unsigned FIELDS   = 2,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  bcd_field_timer_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t              state_q, state_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [8*FIELDS-1:0] preset_q, preset_d;
  logic                mode_q, mode_d;
  logic                done_q, done_d;

  logic [8*FIELDS-1:0] digits;
  logic [FIELDS-1:0]   inc_v, dec_v, carry_v, borrow_v, zero_v, max_v;
  logic [FIELDS-1:0]   set_inc_v;
  logic                inc0, dec0, clr_all, load_all;
  logic                tick, all_zero, all_max, upper_zero, upper_max;
  logic                cur_term, next_term;

  assign inc_v[0] = inc0;
  assign dec_v[0] = dec0;

  for (genvar g = 0; g < FIELDS; g++) begin : g_field
    if (g > 0) begin : g_chain
      assign inc_v[g] = carry_v[g-1];
      assign dec_v[g] = borrow_v[g-1];
    end
    bcd_mod60_field u_field (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc_v[g]),
      .dec      (dec_v[g]),
      .set_inc  (set_inc_v[g]),
      .clr      (clr_all),
      .load     (load_all),
      .load_val (preset_q[8*g +: 8]),
      .q        (digits[8*g +: 8]),
      .carry    (carry_v[g]),
      .borrow   (borrow_v[g]),
      .is_zero  (zero_v[g]),
      .is_max   (max_v[g])
    );
  end

  assign tick     = (pre_q == PW'(TICK_DIV - 1));
  assign all_zero = &zero_v;
  assign all_max  = &max_v;

  // Terminal detection. next_term looks one step ahead so DONE is entered on
  // the same edge the terminal value is loaded; cur_term stops a run that
  // starts already at 59..59 from wrapping.
  always_comb begin
    upper_zero = 1'b1;
    upper_max  = 1'b1;
    for (int unsigned i = 1; i < FIELDS; i++) begin
      upper_zero = upper_zero & zero_v[i];
      upper_max  = upper_max  & max_v[i];
    end
    cur_term  = mode_q ? all_zero : all_max;
    next_term = mode_q ? (upper_zero && digits[7:0] == 8'h01)
                       : (upper_max  && digits[7:0] == 8'h58);
  end

  // FSM next state, prescaler, preset and field controls.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    preset_d  = preset_q;
    mode_d    = mode_q;
    inc0      = 1'b0;
    dec0      = 1'b0;
    set_inc_v = '0;
    clr_all   = 1'b0;
    load_all  = 1'b0;
    if (bus.pb_clear) begin
      clr_all  = 1'b1;
      preset_d = '0;
      pre_d    = '0;
      state_d  = ST_SET;
    end else begin
      unique case (state_q)
        ST_SET: begin
          if (bus.pb_start) begin
            if (!(bus.mode && all_zero)) begin
              preset_d = digits;
              mode_d   = bus.mode;
              pre_d    = '0;
              state_d  = ST_RUN;
            end
          end else begin
            set_inc_v = bus.pb_set;
          end
        end
        ST_RUN: begin
          if (bus.pb_start) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            pre_d = '0;
            if (cur_term) begin
              state_d = ST_DONE;
            end else begin
              inc0 = !mode_q;
              dec0 = mode_q;
              if (next_term) state_d = ST_DONE;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (bus.pb_start) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (bus.pb_start) begin
            load_all = 1'b1;
            state_d  = ST_SET;
          end
        end
        default: state_d = ST_SET;
      endcase
    end
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_SET;
      pre_q    <= '0;
      preset_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      preset_q <= preset_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  assign bus.digits  = digits;
  assign bus.state   = state_q;
  assign bus.running = (state_q == ST_RUN);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_field_timer.sv
// Directed bench for bcd_field_timer (FIELDS = 2, TICK_DIV = 4).
module tb_bcd_field_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  bcd_field_timer_if #(.FIELDS(2)) bus ();

  bcd_field_timer #(.FIELDS(2), .TICK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  set;
    logic        start;
    logic        clear;
    logic        mode;
    logic [15:0] exp_digits;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.pb_start = 1'b1;
    step();
    bus.pb_start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.pb_clear = 1'b1;
    step();
    bus.pb_clear = 1'b0;
  endtask

  task automatic chk_status(input string name, input logic [15:0] d, input logic [1:0] s);
    chk({name, ".digits"}, 32'(bus.digits), 32'(d));
    chk({name, ".state"}, 32'(bus.state), 32'(s));
  endtask

  initial begin
    bus.pb_start = 1'b0;
    bus.pb_clear = 1'b0;
    bus.pb_set   = '0;
    bus.mode     = 1'b0;

    // Test 1: reset
    step(); step();
    chk_status("reset", 16'h0000, 2'b00);
    chk("reset.running", 32'(bus.running), 0);
    chk("reset.done", 32'(bus.done), 0);
    rst_n = 1'b1;

    // Table of single-cycle SET/PAUSE interactions starting from 00:00
    vecs[0] = '{2'b01, 1'b0, 1'b0, 1'b0, 16'h0001, 2'b00};
    vecs[1] = '{2'b11, 1'b0, 1'b0, 1'b0, 16'h0102, 2'b00};
    vecs[2] = '{2'b10, 1'b0, 1'b0, 1'b0, 16'h0202, 2'b00};
    vecs[3] = '{2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00};
    vecs[4] = '{2'b00, 1'b1, 1'b0, 1'b1, 16'h0000, 2'b00};
    vecs[5] = '{2'b01, 1'b0, 1'b0, 1'b0, 16'h0001, 2'b00};
    vecs[6] = '{2'b01, 1'b1, 1'b0, 1'b0, 16'h0001, 2'b01};
    vecs[7] = '{2'b00, 1'b1, 1'b0, 1'b0, 16'h0001, 2'b10};
    vecs[8] = '{2'b01, 1'b0, 1'b0, 1'b0, 16'h0001, 2'b10};
    vecs[9] = '{2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00};
    for (int i = 0; i < 10; i++) begin
      bus.pb_set   = vecs[i].set;
      bus.pb_start = vecs[i].start;
      bus.pb_clear = vecs[i].clear;
      bus.mode     = vecs[i].mode;
      step();
      bus.pb_set = '0; bus.pb_start = 1'b0; bus.pb_clear = 1'b0;
      chk($sformatf("vec%0d.digits", i), 32'(bus.digits), 32'(vecs[i].exp_digits));
      chk($sformatf("vec%0d.state", i), 32'(bus.state), 32'(vecs[i].exp_state));
      chk($sformatf("vec%0d.running", i), 32'(bus.running), 32'(vecs[i].exp_state == 2'b01));
    end

    // Test 2: field wrap without carry
    for (int i = 0; i < 61; i++) begin bus.pb_set = 2'b01; step(); end
    for (int i = 0; i < 3; i++)  begin bus.pb_set = 2'b10; step(); end
    bus.pb_set = '0;
    chk_status("setwrap", 16'h0301, 2'b00);

    // Test 3: count down 01:01 to 00:00
    pulse_clear();
    bus.pb_set = 2'b11; step(); bus.pb_set = '0;
    bus.mode = 1'b1;
    pulse_start();
    bus.mode = 1'b0;
    chk_status("dn.start", 16'h0101, 2'b01);
    repeat (3) step();
    chk_status("dn.pre3", 16'h0101, 2'b01);
    step();
    chk_status("dn.t1", 16'h0100, 2'b01);
    repeat (4) step();
    chk_status("dn.t2", 16'h0059, 2'b01);
    repeat (58 * 4) step();
    chk_status("dn.t60", 16'h0001, 2'b01);
    repeat (3) step();
    chk("dn.predone", 32'(bus.done), 0);
    step();
    chk_status("dn.term", 16'h0000, 2'b11);
    chk("dn.done", 32'(bus.done), 1);
    chk("dn.running", 32'(bus.running), 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_status("dn.hold", 16'h0000, 2'b11);
      chk("dn.hold.done", 32'(bus.done), 0);
    end
    pulse_start();
    chk_status("dn.reload", 16'h0101, 2'b00);

    // Test 4: pause keeps the partial prescaler count
    pulse_start();
    step(); step();
    pulse_start();
    chk_status("pz.enter", 16'h0101, 2'b10);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_status("pz.hold", 16'h0101, 2'b10);
    end
    pulse_start();
    chk_status("pz.resume", 16'h0101, 2'b01);
    step();
    chk_status("pz.r1", 16'h0101, 2'b01);
    step();
    chk_status("pz.r2", 16'h0102, 2'b01);
    repeat (3) step();
    pulse_start();
    chk_status("pz.ticklost", 16'h0102, 2'b10);
    pulse_start();
    step();
    chk_status("pz.heldtick", 16'h0103, 2'b01);

    // Test 5: count up 59:58 to 59:59 and reload
    pulse_clear();
    for (int i = 0; i < 58; i++) begin bus.pb_set = 2'b11; step(); end
    bus.pb_set = 2'b10; step(); bus.pb_set = '0;
    chk_status("up.preset", 16'h5958, 2'b00);
    pulse_start();
    repeat (3) step();
    chk_status("up.pre3", 16'h5958, 2'b01);
    step();
    chk_status("up.term", 16'h5959, 2'b11);
    chk("up.done", 32'(bus.done), 1);
    step();
    chk("up.done_off", 32'(bus.done), 0);
    chk_status("up.hold", 16'h5959, 2'b11);
    pulse_start();
    chk_status("up.reload", 16'h5958, 2'b00);

    // Test 6: clear beats start; reset mid-run
    pulse_clear();
    bus.pb_set = 2'b01; step(); bus.pb_set = '0;
    pulse_start();
    step();
    bus.pb_start = 1'b1; bus.pb_clear = 1'b1;
    step();
    bus.pb_start = 1'b0; bus.pb_clear = 1'b0;
    chk_status("clr.prio", 16'h0000, 2'b00);
    bus.pb_set = 2'b11; step(); bus.pb_set = '0;
    pulse_start();
    step();
    chk_status("rst.run", 16'h0101, 2'b01);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_status("rst.mid", 16'h0000, 2'b00);
    chk("rst.running", 32'(bus.running), 0);
    chk("rst.done", 32'(bus.done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
